// File: rtl/kf_seq_ctrl.sv
// Micro-sequencer for the Kalman-filter mem_reg/ALU datapath: fetch, latch, execute, measurement wait.
// Optional illegal-opcode trap enabled by defining KF_SEQ_ERRCHK_EN.
module kf_seq_ctrl #(
  parameter int unsigned ADDRW   = 5,
  parameter int unsigned PCW     = 8,
  parameter int unsigned ALU_LAT = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [PCW-1:0]          base_addr,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [PCW-1:0]          prog_addr,
  output logic                    prog_rd,
  input  logic [6+2*ADDRW-1:0]    instr,
  input  logic                    meas_valid,
  output logic                    meas_ack,
  output logic [ADDRW-1:0]        dira,
  output logic [ADDRW-1:0]        dirb,
  output logic                    write,
  output logic                    rq_we,
  output logic                    rd_we,
  output logic [2:0]              alu_op
);

  localparam int unsigned IW = 6 + 2*ADDRW;
  localparam int unsigned CW = 3;
  localparam logic [CW-1:0] LAT = CW'(ALU_LAT);

  localparam logic [2:0] OP_ADD   = 3'b001;
  localparam logic [2:0] OP_SUB   = 3'b010;
  localparam logic [2:0] OP_MUL   = 3'b011;
  localparam logic [2:0] OP_MOV   = 3'b100;
  localparam logic [2:0] OP_WAITM = 3'b101;
  localparam logic [2:0] OP_HALT  = 3'b111;
`ifdef KF_SEQ_ERRCHK_EN
  localparam logic [2:0] OP_RSVD  = 3'b110;
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LATCH = 3'd2,
    S_EXEC  = 3'd3,
    S_WAITM = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t           r_state;
  logic [PCW-1:0]   r_pc;
  logic [IW-1:0]    r_ir;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_prog_rd;
  logic [ADDRW-1:0] r_dira;
  logic [ADDRW-1:0] r_dirb;
  logic [2:0]       r_alu_op;
  logic [2:0]       r_en;      // {rd_we, rq_we, write}

  logic [2:0]       w_op;
  logic [1:0]       w_tgt;
  logic [ADDRW-1:0] w_dira;
  logic [ADDRW-1:0] w_dirb;
  logic [2:0]       w_en_new;
  logic [2:0]       w_en_ir;
  logic             w_unused;

  // Write-enable one-hot for a data-producing op; NOP/WAITM/HALT/tgt=11 produce none.
  function automatic logic [2:0] en_of(input logic [2:0] op, input logic [1:0] tgt);
    logic [2:0] v;
    v = 3'b000;
    if (op == OP_ADD || op == OP_SUB || op == OP_MUL || op == OP_MOV) begin
      case (tgt)
        2'b00:   v = 3'b001;
        2'b01:   v = 3'b010;
        2'b10:   v = 3'b100;
        default: v = 3'b000;
      endcase
    end
    return v;
  endfunction

  assign w_op     = instr[IW-1 -: 3];
  assign w_tgt    = instr[IW-4 -: 2];
  assign w_dira   = instr[IW-6 -: ADDRW];
  assign w_dirb   = instr[ADDRW:1];
  assign w_en_new = en_of(w_op, w_tgt);
  assign w_en_ir  = en_of(r_ir[IW-1 -: 3], r_ir[IW-4 -: 2]);
  assign w_unused = ^{r_ir[IW-6:0], instr[0]};

`ifdef KF_SEQ_ERRCHK_EN
  logic r_err;
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_pc      <= '0;
      r_ir      <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_prog_rd <= 1'b0;
      r_dira    <= '0;
      r_dirb    <= '0;
      r_alu_op  <= 3'b000;
      r_en      <= 3'b000;
`ifdef KF_SEQ_ERRCHK_EN
      r_err     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_pc      <= base_addr;
            r_busy    <= 1'b1;
            r_prog_rd <= 1'b1;
            r_state   <= S_FETCH;
`ifdef KF_SEQ_ERRCHK_EN
            r_err     <= 1'b0;
`endif
          end
        end
        S_FETCH: begin
          r_prog_rd <= 1'b0;
          r_state   <= S_LATCH;
        end
        S_LATCH: begin
          r_ir <= instr;
          case (w_op)
            OP_HALT: begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
            OP_WAITM: r_state <= S_WAITM;
`ifdef KF_SEQ_ERRCHK_EN
            OP_RSVD: begin
              r_err   <= 1'b1;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
`endif
            default: begin
              r_cnt    <= '0;
              r_dira   <= w_dira;
              r_dirb   <= w_dirb;
              r_alu_op <= w_op;
              r_en     <= (LAT == '0) ? w_en_new : 3'b000;
              r_state  <= S_EXEC;
            end
          endcase
        end
        // Enable is raised only for the last of the ALU_LAT+1 hold cycles.
        S_EXEC: begin
          if (r_cnt == LAT) begin
            r_en      <= 3'b000;
            r_alu_op  <= 3'b000;
            r_pc      <= r_pc + PCW'(1);
            r_prog_rd <= 1'b1;
            r_state   <= S_FETCH;
          end else begin
            r_cnt <= r_cnt + CW'(1);
            if (CW'(r_cnt + CW'(1)) == LAT) r_en <= w_en_ir;
          end
        end
        S_WAITM: begin
          if (meas_valid) begin
            r_pc      <= r_pc + PCW'(1);
            r_prog_rd <= 1'b1;
            r_state   <= S_FETCH;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Ack is qualified by state so meas_valid outside WAITM has no effect.
  assign meas_ack  = (r_state == S_WAITM) && meas_valid;
  assign busy      = r_busy;
  assign done      = r_done;
  assign prog_addr = r_pc;
  assign prog_rd   = r_prog_rd;
  assign dira      = r_dira;
  assign dirb      = r_dirb;
  assign alu_op    = r_alu_op;
  assign write     = r_en[0];
  assign rq_we     = r_en[1];
  assign rd_we     = r_en[2];

endmodule

// File: tb/tb_kf_seq_ctrl.sv
// Directed bench for kf_seq_ctrl: one instance with ALU_LAT=0 and one with ALU_LAT=2, each fed by a sync ROM.
module tb_kf_seq_ctrl;

  logic clk;
  logic rst_n;

  logic        start0, start1;
  logic [7:0]  base0, base1;
  logic        busy0, busy1, done0, done1, err0, err1;
  logic [7:0]  paddr0, paddr1;
  logic        prd0, prd1;
  logic [15:0] instr0, instr1;
  logic        mv0, mv1, mack0, mack1;
  logic [4:0]  dira0, dira1, dirb0, dirb1;
  logic        wr0, wr1, rq0, rq1, rd0, rd1;
  logic [2:0]  op0, op1;

  logic [15:0] rom0 [256];
  logic [15:0] rom1 [256];

  int total;
  int bad;

  kf_seq_ctrl #(.ADDRW(5), .PCW(8), .ALU_LAT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .base_addr(base0),
    .busy(busy0), .done(done0), .err(err0), .prog_addr(paddr0), .prog_rd(prd0),
    .instr(instr0), .meas_valid(mv0), .meas_ack(mack0), .dira(dira0), .dirb(dirb0),
    .write(wr0), .rq_we(rq0), .rd_we(rd0), .alu_op(op0)
  );

  kf_seq_ctrl #(.ADDRW(5), .PCW(8), .ALU_LAT(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .base_addr(base1),
    .busy(busy1), .done(done1), .err(err1), .prog_addr(paddr1), .prog_rd(prd1),
    .instr(instr1), .meas_valid(mv1), .meas_ack(mack1), .dira(dira1), .dirb(dirb1),
    .write(wr1), .rq_we(rq1), .rd_we(rd1), .alu_op(op1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous ROMs: data valid the cycle after prog_rd.
  initial begin
    instr0 = '0;
    instr1 = '0;
  end
  always @(posedge clk) begin
    if (prd0) instr0 <= rom0[paddr0];
    if (prd1) instr1 <= rom1[paddr1];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [15:0] enc(input logic [2:0] op, input logic [1:0] tgt,
                                      input logic [4:0] a, input logic [4:0] b);
    return {op, tgt, a, b, 1'b0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 256; i++) begin
      rom0[i] = 16'h0000;
      rom1[i] = 16'h0000;
    end
    rom0[8'h10] = enc(3'b001, 2'b00, 5'd3, 5'd4);   // ADD bank
    rom0[8'h11] = enc(3'b111, 2'b11, 5'd0, 5'd0);   // HALT
    rom0[8'h30] = enc(3'b101, 2'b11, 5'd0, 5'd0);   // WAITM
    rom0[8'h31] = enc(3'b100, 2'b10, 5'd5, 5'd6);   // MOV RD
    rom0[8'h32] = enc(3'b111, 2'b11, 5'd0, 5'd0);
    rom0[8'h50] = enc(3'b110, 2'b00, 5'd2, 5'd3);   // reserved op
    rom0[8'h51] = enc(3'b111, 2'b11, 5'd0, 5'd0);
    rom0[8'hFF] = enc(3'b000, 2'b00, 5'd1, 5'd1);   // NOP at top, wraps to 0x00
    rom0[8'h00] = enc(3'b111, 2'b11, 5'd0, 5'd0);
    rom1[8'h20] = enc(3'b011, 2'b01, 5'd7, 5'd9);   // MUL RQ
    rom1[8'h21] = enc(3'b111, 2'b11, 5'd0, 5'd0);
    rom1[8'h40] = enc(3'b001, 2'b00, 5'd1, 5'd2);   // ADD bank (aborted)
    rom1[8'h41] = enc(3'b111, 2'b11, 5'd0, 5'd0);

    // Reset with start held high
    rst_n = 1'b0; start0 = 1'b1; start1 = 1'b1; base0 = 8'h10; base1 = 8'h20;
    mv0 = 1'b0; mv1 = 1'b0;
    step(); step();
    chk("rst_busy0", 32'(busy0), 32'd0);
    chk("rst_busy1", 32'(busy1), 32'd0);
    chk("rst_ctl0", 32'({done0, err0, prd0, mack0, wr0, rq0, rd0}), 32'd0);
    chk("rst_ctl1", 32'({done1, err1, prd1, mack1, wr1, rq1, rd1}), 32'd0);
    chk("rst_addr0", 32'({paddr0, dira0, dirb0, op0}), 32'd0);
    start0 = 1'b0; start1 = 1'b0;
    rst_n = 1'b1;
    step(); step();
    chk("post_rst_idle0", 32'({busy0, prd0}), 32'd0);
    chk("post_rst_idle1", 32'({busy1, prd1}), 32'd0);

    // ADD tgt=bank, ALU_LAT=0, then HALT
    start0 = 1'b1; base0 = 8'h10;
    step();                                           // FETCH
    start0 = 1'b0;
    chk("a_fetch", 32'({busy0, prd0, paddr0}), 32'({1'b1, 1'b1, 8'h10}));
    step();                                           // LATCH
    chk("a_latch", 32'({prd0, wr0}), 32'd0);
    step();                                           // EXEC
    chk("a_exec_en", 32'({wr0, rq0, rd0}), 32'b100);
    chk("a_exec_addr", 32'({dira0, dirb0, op0}), 32'({5'd3, 5'd4, 3'b001}));
    step();                                           // FETCH
    chk("a_fetch2", 32'({wr0, prd0, paddr0}), 32'({1'b0, 1'b1, 8'h11}));
    step();                                           // LATCH
    chk("a_latch2", 32'({done0, wr0}), 32'd0);
    step();                                           // DONE
    chk("a_done", 32'({done0, busy0, wr0}), 32'b110);
    step();                                           // IDLE
    chk("a_idle", 32'({done0, busy0}), 32'd0);

    // MUL tgt=RQ, ALU_LAT=2
    start1 = 1'b1; base1 = 8'h20;
    step();
    start1 = 1'b0;
    chk("b_fetch", 32'({prd1, paddr1}), 32'({1'b1, 8'h20}));
    step();
    step();                                           // EXEC cycle 1
    chk("b_c1", 32'({dira1, dirb1, op1, wr1, rq1, rd1}), 32'({5'd7, 5'd9, 3'b011, 3'b000}));
    step();                                           // EXEC cycle 2
    chk("b_c2", 32'({dira1, dirb1, op1, wr1, rq1, rd1}), 32'({5'd7, 5'd9, 3'b011, 3'b000}));
    step();                                           // EXEC cycle 3
    chk("b_c3", 32'({dira1, dirb1, op1, wr1, rq1, rd1}), 32'({5'd7, 5'd9, 3'b011, 3'b010}));
    step();                                           // FETCH
    chk("b_fetch2", 32'({wr1, rq1, rd1, prd1, paddr1}), 32'({3'b000, 1'b1, 8'h21}));
    step(); step();                                   // LATCH, DONE
    chk("b_done", 32'({done1, busy1}), 32'b11);
    step();
    chk("b_idle", 32'({done1, busy1}), 32'd0);

    // WAITM then MOV tgt=RD; meas_valid outside WAITM is ignored
    start0 = 1'b1; base0 = 8'h30;
    step();                                           // FETCH
    start0 = 1'b0;
    mv0 = 1'b1;
    #1;
    chk("c_ignore_fetch", 32'(mack0), 32'd0);
    step();                                           // LATCH
    mv0 = 1'b0;
    step();                                           // WAITM entry
    for (int i = 0; i < 5; i++) begin
      chk("c_wait", 32'({mack0, busy0, prd0, wr0, rq0, rd0}), 32'b010000);
      step();
    end
    mv0 = 1'b1;
    #1;
    chk("c_ack", 32'({mack0, paddr0}), 32'({1'b1, 8'h30}));
    step();                                           // FETCH
    mv0 = 1'b0;
    #1;
    chk("c_fetch", 32'({mack0, prd0, paddr0}), 32'({1'b0, 1'b1, 8'h31}));
    step();                                           // LATCH
    step();                                           // EXEC
    chk("c_mov", 32'({dira0, dirb0, op0, wr0, rq0, rd0}), 32'({5'd5, 5'd6, 3'b100, 3'b001}));
    step();
    chk("c_fetch2", 32'({rd0, paddr0}), 32'({1'b0, 8'h32}));
    step(); step();
    chk("c_done", 32'({done0, mack0}), 32'b10);
    step();

    // pc wraps from 0xFF to 0x00; NOP gives no enables
    start0 = 1'b1; base0 = 8'hFF;
    step();
    start0 = 1'b0;
    step(); step();                                   // EXEC of NOP
    chk("w_nop", 32'({wr0, rq0, rd0, op0}), 32'd0);
    step();
    chk("w_wrap", 32'({prd0, paddr0}), 32'({1'b1, 8'h00}));
    step(); step();
    chk("w_done", 32'(done0), 32'd1);
    step();

    // Abort in second EXEC cycle of ADD with ALU_LAT=2
    start1 = 1'b1; base1 = 8'h40;
    step();
    start1 = 1'b0;
    step(); step(); step();                           // EXEC cycle 2
    chk("d_pre", 32'({busy1, wr1, dira1}), 32'({1'b1, 1'b0, 5'd1}));
    rst_n = 1'b0;
    #1;
    chk("d_abort", 32'({busy1, wr1, rq1, rd1, prd1, dira1, op1}), 32'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("d_hold", 32'({busy1, wr1}), 32'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("d_after", 32'({busy1, wr1, prd1}), 32'd0);
    end

    // Reserved opcode 110
    start0 = 1'b1; base0 = 8'h50;
    step();
    start0 = 1'b0;
    step(); step();
`ifdef KF_SEQ_ERRCHK_EN
    chk("e_trap", 32'({done0, err0, busy0, wr0, rq0, rd0}), 32'b111000);
    step();
    chk("e_sticky", 32'({err0, busy0}), 32'b10);
    start0 = 1'b1; base0 = 8'h51;
    step();
    start0 = 1'b0;
    chk("e_clear", 32'({err0, busy0}), 32'b01);
    step(); step();
    chk("e_done2", 32'({done0, err0}), 32'b10);
`else
    chk("e_nop", 32'({done0, err0, wr0, rq0, rd0, op0}), 32'({5'b00000, 3'b110}));
    step();
    chk("e_next", 32'({prd0, paddr0}), 32'({1'b1, 8'h51}));
    step(); step();
    chk("e_done", 32'({done0, err0}), 32'b10);
`endif
    step();
    chk("e_idle", 32'(busy0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
